// File: rtl/psram_bist_pkg.sv
// Shared types and constants for the PSRAM built-in self-test sequencer.
package psram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL_WAIT,
    ST_WR_CMD,
    ST_WR_GAP,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RD_GAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_ADDR_XOR = 2'd1;
  localparam logic [1:0] MODE_LFSR     = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois step: the bit shifted out selects the toggle mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/psram_bist_pattern.sv
// Test-pattern source: word value from mode, seed, address and a 32-bit LFSR
// that is re-seeded at the start of every pass and stepped once per word.
module psram_bist_pattern
  import psram_bist_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  input  logic              reseed,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0] lfsr;
  logic [31:0] seed32;

  assign seed32 = 32'(seed);

  // An all-zero state would lock the LFSR, so a zero seed starts it at 1.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      lfsr <= 32'd1;
    end else if (reseed) begin
      lfsr <= (seed32 == 32'd0) ? 32'd1 : seed32;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    pattern = seed;
    case (mode)
      MODE_ADDR_XOR: pattern = seed ^ DATA_W'(addr);
      MODE_LFSR:     pattern = DATA_W'(lfsr);
      default:       pattern = seed;
    endcase
  end

endmodule

// File: rtl/psram_bist.sv
// PSRAM BIST sequencer: writes a pattern over a word range, reads it back,
// compares each word and reports status; optionally repeats read passes.
module psram_bist
  import psram_bist_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_STEP = 1,
  parameter int WR_GAP    = 255,
  parameter int RD_GAP    = 200,
  parameter int TIMEOUT   = 1023
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   seed,
  input  logic                continuous,
  input  logic                ip_init_calib,
  output logic                ip_cmd,
  output logic                ip_cmd_en,
  output logic [ADDR_W-1:0]   ip_addr,
  output logic [DATA_W-1:0]   ip_wr_data,
  output logic [DATA_W/8-1:0] ip_data_mask,
  input  logic [DATA_W-1:0]   ip_rd_data,
  input  logic                ip_rd_data_valid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout_err,
  output logic                abort_err,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_fail_addr,
  output logic [DATA_W-1:0]   first_fail_data,
  output logic [DATA_W-1:0]   last_rd_data,
  output logic [15:0]         pass_count
);

  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [31:0]       WR_GAP_C  = 32'(WR_GAP);
  localparam logic [31:0]       RD_GAP_C  = 32'(RD_GAP);
  localparam logic [31:0]       TIMEOUT_C = 32'(TIMEOUT);

  state_t            state;
  logic [2:0]        cal_sync;
  logic              cal_ok;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              cont_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       cnt;
  logic              last_word;
  logic              wr_gap_end;
  logic              rd_gap_end;
  logic              calib_lost;
  logic              pat_reseed;
  logic              pat_advance;
  logic [DATA_W-1:0] pattern;

  assign ip_data_mask = '0;
  assign cal_ok       = cal_sync[2];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cal_sync <= 3'b000;
    end else begin
      cal_sync <= {cal_sync[1:0], ip_init_calib};
    end
  end

  assign last_word  = (idx == LAST_IDX);
  assign wr_gap_end = (state == ST_WR_GAP) && (cnt + 32'd1 >= WR_GAP_C);
  assign rd_gap_end = (state == ST_RD_GAP) && (cnt + 32'd1 >= RD_GAP_C);
  assign calib_lost = !cal_ok && (state inside {ST_WR_CMD, ST_WR_GAP, ST_RD_CMD,
                                                ST_RD_WAIT, ST_RD_GAP});

  // Pattern restarts at word 0 of every pass and steps once per word advance.
  assign pat_reseed  = !calib_lost &&
                       (((state == ST_CAL_WAIT) && cal_ok) ||
                        (wr_gap_end && last_word) ||
                        (rd_gap_end && last_word && cont_q));
  assign pat_advance = !calib_lost && (wr_gap_end || rd_gap_end) && !last_word;

  psram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .sys_clk (sys_clk),
    .rst     (rst),
    .mode    (mode_q),
    .seed    (seed_q),
    .addr    (addr),
    .reseed  (pat_reseed),
    .advance (pat_advance),
    .pattern (pattern)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      ip_cmd          <= 1'b0;
      ip_cmd_en       <= 1'b0;
      ip_addr         <= '0;
      ip_wr_data      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout_err     <= 1'b0;
      abort_err       <= 1'b0;
      err_count       <= 16'd0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      last_rd_data    <= '1;
      pass_count      <= 16'd0;
      mode_q          <= MODE_CONST;
      seed_q          <= '0;
      cont_q          <= 1'b0;
      idx             <= '0;
      addr            <= '0;
      cnt             <= 32'd0;
    end else begin
      ip_cmd_en <= 1'b0;
      if (calib_lost) begin
        abort_err <= 1'b1;
        state     <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              mode_q          <= mode;
              seed_q          <= seed;
              cont_q          <= continuous;
              busy            <= 1'b1;
              done            <= 1'b0;
              pass            <= 1'b0;
              timeout_err     <= 1'b0;
              abort_err       <= 1'b0;
              err_count       <= 16'd0;
              first_fail_addr <= '0;
              first_fail_data <= '0;
              pass_count      <= 16'd0;
              state           <= ST_CAL_WAIT;
            end
          end
          ST_CAL_WAIT: begin
            if (cal_ok) begin
              idx   <= '0;
              addr  <= '0;
              state <= ST_WR_CMD;
            end
          end
          ST_WR_CMD: begin
            ip_cmd     <= 1'b1;
            ip_cmd_en  <= 1'b1;
            ip_addr    <= addr;
            ip_wr_data <= pattern;
            cnt        <= 32'd0;
            state      <= ST_WR_GAP;
          end
          ST_WR_GAP: begin
            if (wr_gap_end) begin
              if (last_word) begin
                idx   <= '0;
                addr  <= '0;
                state <= ST_RD_CMD;
              end else begin
                idx   <= idx + (ADDR_W+1)'(1);
                addr  <= addr + STEP;
                state <= ST_WR_CMD;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_RD_CMD: begin
            ip_cmd    <= 1'b0;
            ip_cmd_en <= 1'b1;
            ip_addr   <= addr;
            cnt       <= 32'd0;
            state     <= ST_RD_WAIT;
          end
          // Saturating error count; the first mismatch is recorded while the count is still zero.
          ST_RD_WAIT: begin
            if (ip_rd_data_valid) begin
              last_rd_data <= ip_rd_data;
              if (ip_rd_data != pattern) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0) begin
                  first_fail_addr <= addr;
                  first_fail_data <= ip_rd_data;
                end
              end
              cnt   <= 32'd0;
              state <= ST_RD_GAP;
            end else if (cnt == TIMEOUT_C) begin
              timeout_err <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_RD_GAP: begin
            if (rd_gap_end) begin
              if (last_word) begin
                pass_count <= pass_count + 16'd1;
                if (cont_q) begin
                  idx   <= '0;
                  addr  <= '0;
                  state <= ST_RD_CMD;
                end else begin
                  state <= ST_DONE;
                end
              end else begin
                idx   <= idx + (ADDR_W+1)'(1);
                addr  <= addr + STEP;
                state <= ST_RD_CMD;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !timeout_err && !abort_err;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_bist.sv
// Randomized self-checking bench for psram_bist with an echoing PSRAM model
// and a behavioural pattern reference.
module tb_psram_bist;

  localparam int AW    = 21;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int STEP  = 3;
  localparam int WGAP  = 8;
  localparam int RGAP  = 3;
  localparam int TMO   = 1023;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic          sys_clk = 1'b0;
  logic          rst, start, continuous, ip_init_calib;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic          ip_cmd, ip_cmd_en;
  logic [AW-1:0] ip_addr;
  logic [DW-1:0] ip_wr_data;
  logic [3:0]    ip_data_mask;
  logic [DW-1:0] ip_rd_data = '0;
  logic          ip_rd_data_valid = 1'b0;
  logic          busy, done, pass, timeout_err, abort_err;
  logic [15:0]   err_count, pass_count;
  logic [AW-1:0] first_fail_addr;
  logic [DW-1:0] first_fail_data, last_rd_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  psram_bist #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_STEP(STEP),
    .WR_GAP(WGAP), .RD_GAP(RGAP), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .continuous(continuous), .ip_init_calib(ip_init_calib),
    .ip_cmd(ip_cmd), .ip_cmd_en(ip_cmd_en), .ip_addr(ip_addr),
    .ip_wr_data(ip_wr_data), .ip_data_mask(ip_data_mask),
    .ip_rd_data(ip_rd_data), .ip_rd_data_valid(ip_rd_data_valid),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .abort_err(abort_err), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data),
    .last_rd_data(last_rd_data), .pass_count(pass_count)
  );

  // PSRAM model: stores writes, returns reads after a random latency, can
  // corrupt one address and can inject stray valid strobes during writes.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  bit            respond = 1'b1;
  bit            spurious = 1'b0;
  logic [AW-1:0] corrupt_addr = '1;
  logic [DW-1:0] corrupt_mask = '0;
  bit            rd_pending = 1'b0;
  int            rd_delay = 0;
  logic [AW-1:0] rd_addr = '0;
  int            rd_count = 0;

  always @(negedge sys_clk) begin
    ip_rd_data_valid = 1'b0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        ip_rd_data_valid = 1'b1;
        ip_rd_data = (mem.exists(rd_addr) ? mem[rd_addr] : '0) ^
                     ((rd_addr == corrupt_addr) ? corrupt_mask : '0);
        rd_pending = 1'b0;
        rd_count++;
      end else begin
        rd_delay--;
      end
    end
    if (ip_cmd_en) begin
      if (ip_cmd) begin
        mem[ip_addr] = ip_wr_data;
        wr_q.push_back('{a: ip_addr, d: ip_wr_data});
        if (spurious) begin
          ip_rd_data_valid = 1'b1;
          ip_rd_data = $urandom;
        end
      end else if (respond) begin
        rd_pending = 1'b1;
        rd_delay = $urandom_range(0, 4);
        rd_addr = ip_addr;
      end
    end
  end

  function automatic logic [AW-1:0] word_addr(input int i);
    return AW'(i * STEP);
  endfunction

  // Expected word i of a pass, straight from the pattern rules.
  function automatic logic [31:0] exp_word(input logic [1:0] m, input logic [31:0] s, input int i);
    logic [31:0] v;
    case (m)
      2'd1: v = s ^ 32'(word_addr(i));
      2'd2: begin
        v = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
      end
      default: v = s;
    endcase
    return v;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [31:0] s, input logic c);
    @(negedge sys_clk);
    mode = m; seed = s; continuous = c; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; mode = 2'($urandom); seed = $urandom; continuous = !c;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge sys_clk);
      ok = (done === 1'b1);
    end
  endtask

  task automatic test_reset(input string tag);
    vectors++;
    if ({ip_cmd_en, ip_cmd, ip_addr, ip_wr_data, ip_data_mask} !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s ip_outputs: got en=%b cmd=%b addr=%h wd=%h mask=%h required all 0",
               tag, ip_cmd_en, ip_cmd, ip_addr, ip_wr_data, ip_data_mask);
    end
    vectors++;
    if ({busy, done, pass, timeout_err, abort_err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL %s status_flags: got %b required 00000", tag,
               {busy, done, pass, timeout_err, abort_err});
    end
    vectors++;
    if ({err_count, pass_count, first_fail_addr, first_fail_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s counters: got err=%0d passes=%0d ffa=%h ffd=%h required 0",
               tag, err_count, pass_count, first_fail_addr, first_fail_data);
    end
    vectors++;
    if (last_rd_data !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("[TB] FAIL %s last_rd_data: got %h required ffffffff", tag, last_rd_data);
    end
  endtask

  task automatic test_pattern(input string tag, input logic [1:0] m, input logic [31:0] s,
                              input int cidx, input logic [31:0] cmask, input bit poke);
    int wbase, errs;
    bit ok;
    logic [31:0] e, rd, ffd, lastd;
    logic [AW-1:0] ffa;
    respond = 1'b1; spurious = 1'b1; corrupt_mask = cmask;
    corrupt_addr = (cidx >= 0) ? word_addr(cidx) : '1;
    wbase = wr_q.size(); errs = 0; ffa = '0; ffd = '0; lastd = '0;
    do_start(m, s, 1'b0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s busy_after_start: got busy=%b done=%b required 1/0", tag, busy, done);
    end
    if (poke) begin
      repeat (20) @(negedge sys_clk);
      start = 1'b1; mode = 2'd0; seed = $urandom; continuous = 1'b1;
      @(negedge sys_clk);
      start = 1'b0; continuous = 1'b0;
    end
    wait_done(3000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s done_wait: got no done within budget required done=1", tag);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e  = exp_word(m, s, i);
      rd = e ^ ((i == cidx) ? cmask : 32'd0);
      if (rd !== e) begin
        if (errs == 0) begin ffa = word_addr(i); ffd = rd; end
        errs++;
      end
      lastd = rd;
    end
    vectors++;
    if (pass !== (errs == 0) || timeout_err !== 1'b0 || abort_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s result_flags: got pass=%b to=%b ab=%b busy=%b required pass=%b 0 0 0",
               tag, pass, timeout_err, abort_err, busy, errs == 0);
    end
    vectors++;
    if (err_count !== 16'(errs)) begin
      miscompares++;
      $display("[TB] FAIL %s err_count: got %0d required %0d", tag, err_count, errs);
    end
    vectors++;
    if (first_fail_addr !== ffa || first_fail_data !== ffd) begin
      miscompares++;
      $display("[TB] FAIL %s first_fail: got %h/%h required %h/%h",
               tag, first_fail_addr, first_fail_data, ffa, ffd);
    end
    vectors++;
    if (last_rd_data !== lastd || pass_count !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL %s last_rd/pass_count: got %h/%0d required %h/1",
               tag, last_rd_data, pass_count, lastd);
    end
    vectors++;
    if (wr_q.size() - wbase !== DEPTH) begin
      miscompares++;
      $display("[TB] FAIL %s write_count: got %0d required %0d", tag, wr_q.size() - wbase, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++;
        if (wr_q[wbase+i].a !== word_addr(i) || wr_q[wbase+i].d !== exp_word(m, s, i)) begin
          miscompares++;
          $display("[TB] FAIL %s write[%0d]: got %h/%h required %h/%h", tag, i,
                   wr_q[wbase+i].a, wr_q[wbase+i].d, word_addr(i), exp_word(m, s, i));
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok, hit;
    int n;
    respond = 1'b0; spurious = 1'b0;
    do_start(2'd0, $urandom, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge sys_clk);
      ok = (ip_cmd_en === 1'b1 && ip_cmd === 1'b0);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL timeout read_cmd: got no read command required one");
    end
    n = 0; hit = 1'b0;
    while (!hit && n < 2000) begin
      @(posedge sys_clk);
      #1;
      n++;
      hit = (timeout_err === 1'b1);
    end
    vectors++;
    if (!hit || n != TMO + 1) begin
      miscompares++;
      $display("[TB] FAIL timeout latency: got %0d cycles (seen=%b) required %0d", n, hit, TMO + 1);
    end
    wait_done(100, ok);
    vectors++;
    if (!ok || pass !== 1'b0 || err_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL timeout result: got done=%b pass=%b err=%0d required 1/0/0",
               done, pass, err_count);
    end
    respond = 1'b1;
  endtask

  task automatic test_continuous();
    int wbase, rbase;
    bit ok;
    respond = 1'b1; spurious = 1'b0; corrupt_addr = '1; corrupt_mask = '0;
    wbase = wr_q.size(); rbase = rd_count;
    do_start(2'd2, $urandom, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      @(negedge sys_clk);
      ok = (pass_count === 16'd3);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL continuous pass_count: got %0d required 3", pass_count);
    end
    vectors++;
    if (wr_q.size() - wbase != DEPTH || rd_count - rbase != 3 * DEPTH) begin
      miscompares++;
      $display("[TB] FAIL continuous cmd_counts: got wr=%0d rd=%0d required %0d/%0d",
               wr_q.size() - wbase, rd_count - rbase, DEPTH, 3 * DEPTH);
    end
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL continuous status: got busy=%b done=%b err=%0d required 1/0/0",
               busy, done, err_count);
    end
    @(negedge sys_clk); rst = 1'b1;
    @(negedge sys_clk); rst = 1'b0;
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_abort();
    bit ok;
    int en_seen;
    respond = 1'b1; spurious = 1'b0;
    do_start(2'd1, $urandom, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge sys_clk);
      ok = (ip_cmd_en === 1'b1 && ip_cmd === 1'b1);
    end
    ip_init_calib = 1'b0;
    en_seen = 0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge sys_clk);
      if (ip_cmd_en !== 1'b0) en_seen++;
      ok = (done === 1'b1);
    end
    vectors++;
    if (!ok || abort_err !== 1'b1 || pass !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort result: got done=%b abort=%b pass=%b to=%b required 1/1/0/0",
               done, abort_err, pass, timeout_err);
    end
    vectors++;
    if (en_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL abort cmd_en_quiet: got %0d strobes required 0", en_seen);
    end
    ip_init_calib = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    respond = 1'b0; spurious = 1'b0;
    do_start(2'd1, $urandom, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge sys_clk);
      ok = (ip_cmd_en === 1'b1 && ip_cmd === 1'b0);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL reset_mid read_cmd: got no read command required one");
    end
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    test_reset("reset_mid");
    rst = 1'b0;
    respond = 1'b1;
    test_pattern("after_reset", 2'($urandom), $urandom, -1, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = '0; continuous = 1'b0; ip_init_calib = 1'b1;
    repeat (3) @(negedge sys_clk);
    test_reset("power_on");
    rst = 1'b0;
    test_pattern("const", 2'd0, 32'h3C85_5AA5, -1, 32'd0, 1'b0);
    test_pattern("lfsr_corrupt5", 2'd2, 32'd1, 5, 32'd1, 1'b1);
    test_pattern("lfsr_seed0", 2'd2, 32'd0, $urandom_range(0, DEPTH - 1), $urandom | 32'd1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      test_pattern("random", 2'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH - 1) : -1,
                   $urandom | 32'h100, 1'b0);
    end
    test_timeout();
    test_continuous();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psram_bist.md
# psram_bist

Parametrised PSRAM built-in self-test sequencer. It sits between the Gowin `PSRAM_Memory_Interface_HS_Top` user port and the cartridge diagnostic logic. After calibration it writes a generated pattern over a configurable word range, reads the range back, compares each word, and reports pass/fail, error count, first-failure details and the last word read. Optional continuous mode repeats the read/verify pass indefinitely, as the single-word bring-up test did for one address.

## Interface
- `ADDR_W`, 21: IP address width.
- `DATA_W`, 32: IP data width; must be 32 in LFSR mode.
- `DEPTH`, 16: number of words tested, 1..2^ADDR_W.
- `ADDR_STEP`, 1: address increment between words.
- `WR_GAP`, 255: idle cycles after each write command.
- `RD_GAP`, 200: idle cycles after each read completes.
- `TIMEOUT`, 1023: cycles allowed from read command to `ip_rd_data_valid`.

Ports:
- `sys_clk`  in  1  system clock (27 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a test; ignored while `busy`.
- `mode`  in  2  pattern select, sampled at start: 0 = constant `seed`, 1 = `addr ^ seed`, 2 = LFSR seeded by `seed`, 3 = reserved (treated as 0).
- `seed`  in  DATA_W  pattern seed, sampled at start.
- `continuous`  in  1  sampled at start; 1 = repeat read passes until `rst`.
- `ip_init_calib`  in  1  IP calibration done; asynchronous, synchronised internally with 3 flops.
- `ip_cmd`  out  1  1 = write, 0 = read.
- `ip_cmd_en`  out  1  command strobe.
- `ip_addr`  out  ADDR_W  command address.
- `ip_wr_data`  out  DATA_W  write data.
- `ip_data_mask`  out  DATA_W/8  always all zeros.
- `ip_rd_data`  in  DATA_W  read data.
- `ip_rd_data_valid`  in  1  read data strobe.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; stays high until the next `start`.
- `pass`  out  1  valid when `done`; 1 means zero errors and no timeout or abort.
- `timeout_err`  out  1  a read timed out.
- `abort_err`  out  1  calibration was lost during the test.
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `first_fail_addr`  out  ADDR_W  address of the first mismatch.
- `first_fail_data`  out  DATA_W  data read at the first mismatch.
- `last_rd_data`  out  DATA_W  most recent read data. Reset value is all ones.
- `pass_count`  out  16  completed read passes; wraps.

## Operation
- States: IDLE → CAL_WAIT → WR_CMD → WR_GAP → (next word, or back to RD_CMD) → RD_CMD → RD_WAIT → RD_GAP → (next word, DONE, or a new read pass).
- IDLE: on `start`, latch `mode`, `seed` and `continuous`. Clear `done`, `pass`, the error outputs, the counters and the first-fail registers. Go to CAL_WAIT.
- CAL_WAIT: wait for synchronised calib high, then set word index = 0 and addr = 0.
- WR_CMD: drive `ip_cmd`=1, `ip_addr`, `ip_wr_data`=pattern(index), and pulse `ip_cmd_en` for exactly one cycle. WR_GAP then waits WR_GAP cycles.
- After the last word is written: re-seed the pattern, reset index and addr, go to RD_CMD.
- RD_CMD: pulse `ip_cmd_en` with `ip_cmd`=0.
- RD_WAIT: on valid, capture `last_rd_data` and compare against the expected pattern. On mismatch, increment `err_count`; if it was the first mismatch, record the address and data. If TIMEOUT cycles elapse with no valid, set `timeout_err` and go to DONE.
- RD_GAP: wait RD_GAP cycles. At the last word, increment `pass_count`. If `continuous`=1, start a new read pass at address 0; otherwise go to DONE.
- DONE: set `done`=1 and `pass`=(err_count==0 && !timeout_err && !abort_err). Go to IDLE.
- Address: `ip_addr` = index*ADDR_STEP, truncated to ADDR_W. Wrap-around is permitted and is not flagged.
- LFSR: 32-bit Galois, polynomial 0x80200003, advances one step per word. A seed of 0 is replaced by 1.
- Calibration drops in any busy state: set `abort_err`, deassert `ip_cmd_en`, go to DONE.
- `ip_rd_data_valid` outside RD_WAIT is ignored.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, `ip_cmd_en`=0, `ip_cmd`=0, `ip_addr`=0, `ip_wr_data`=0, `ip_data_mask`=0. All status outputs are 0 except `last_rd_data`, which is all ones.
- `ip_cmd_en` is high exactly one cycle per command. Address, command and data are stable in that cycle.
- Compare and capture are registered: the outputs update in the cycle after `ip_rd_data_valid`.
- Calibration is seen 3 cycles after `ip_init_calib` rises.
- `rst` mid-operation returns to reset values on the next edge; commands already in flight in the IP are abandoned.
- `busy` rises the cycle after `start`. `done` rises in the same cycle `busy` falls.

## Structure
- Package `psram_bist_pkg`: state enum, mode encodings, LFSR polynomial constant.
- Sub-module `psram_bist_pattern`: a pure function of mode, seed, index and LFSR state, plus the LFSR step and re-seed logic.
- The 3-flop calibration synchroniser lives inline in `psram_bist`.

## Test plan
- mode 0, seed 3C855AA5, DEPTH 4, echoing memory model → `done`=1, `pass`=1, `err_count`=0, `last_rd_data`=3C855AA5.
- mode 2, seed 1, DEPTH 16, model corrupts word 5 by XOR 1 → `err_count`=1, `first_fail_addr`=5, `pass`=0.
- Model never asserts valid, TIMEOUT 1023 → `timeout_err`=1 exactly 1024 cycles after the first read `ip_cmd_en`; `done`=1, `pass`=0.
- `continuous`=1, DEPTH 2 → `pass_count` reaches 3 after three read passes; no further write commands are issued.
- Calibration dropped during WR_GAP → `abort_err`=1, `done`=1, `ip_cmd_en` stays 0.
- `rst` during RD_WAIT → all outputs at reset values next cycle; `start` is accepted afterwards.
